// File: rtl/cues_tok_rx_mem1.sv
// Purpose: receives 4-phase SENDIN/ACKOUT tokens with bundled data into a show-ahead FIFO.
// Latency: SENDIN edge to ACKOUT edge is SYNC_STAGES+1 clocks; a write shows on DVALID/DOUT 1 clock later.
// Backpressure: a full FIFO stalls the acknowledge of keep tokens; discard tokens are never stalled.
//
// Ports:
//   CLK, RESET           single clock, synchronous active-high reset
//   SENDIN/ACKOUT        asynchronous 4-phase request / registered acknowledge
//   EXBIN, DATAIN        bundled branch bit (1 = keep) and data, sampled in the capture cycle
//   DOUT/DVALID/DREADY   clocked show-ahead output stream; DOUT reads 0 while empty
//   LEVEL                FIFO occupancy
//   DROPCNT, DROPCLR     saturating discard counter and its clear; present only when
//                        CUES_RX_DROPCNT_EN is defined
module cues_tok_rx_mem1 #(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     SENDIN,
    input  logic                     EXBIN,
    input  logic [DW-1:0]            DATAIN,
    output logic                     ACKOUT,
    output logic [DW-1:0]            DOUT,
    output logic                     DVALID,
    input  logic                     DREADY,
    output logic [$clog2(DEPTH):0]   LEVEL
`ifdef CUES_RX_DROPCNT_EN
    ,
    output logic [15:0]              DROPCNT,
    input  logic                     DROPCLR
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    // ------------------------------------------------------------------
    // SENDIN synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_req;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SENDIN};
        end
    end

    assign s_req = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          full;
    logic          wr_en;
    logic          rd_en;

    // Fullness comes from the registered level only, so a pop in the same
    // cycle cannot make room for a write; this keeps the write decision
    // independent of DREADY.
    assign full   = (level_q == LW'(DEPTH));
    assign DVALID = (level_q != '0);
    assign rd_en  = DVALID && DREADY;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   ack_q;
    logic   ack_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_req) begin
                    if (!EXBIN) begin
                        // Discarded token: acknowledge regardless of fullness.
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else if (!full) begin
                        wr_en   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (!s_req) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    assign ACKOUT = ack_q;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    // Storage is not reset; DOUT is masked to 0 while empty instead.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= DATAIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign DOUT  = DVALID ? mem[rd_ptr] : '0;
    assign LEVEL = level_q;

`ifdef CUES_RX_DROPCNT_EN
    // ------------------------------------------------------------------
    // Discard counter
    // ------------------------------------------------------------------
    logic        drop;
    logic [15:0] drop_cnt_q;

    // Same condition as the IDLE->ACK discard branch of the FSM.
    assign drop = (state_q == IDLE) && s_req && !EXBIN;

    always_ff @(posedge CLK) begin
        if (RESET || DROPCLR) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign DROPCNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cues_tok_rx_mem1.sv
// Purpose: self-checking bench for cues_tok_rx_mem1 (table of tokens plus corner sequences).
// Latency: checks handshake edge counts and show-ahead output timing.
// Backpressure: exercises FIFO-full stall of ACKOUT and release by a single pop.
module tb_cues_tok_rx_mem1;

    logic       CLK;
    logic       RESET;
    logic       SENDIN;
    logic       EXBIN;
    logic [7:0] DATAIN;
    logic       ACKOUT;
    logic [7:0] DOUT;
    logic       DVALID;
    logic       DREADY;
    logic [2:0] LEVEL;
`ifdef CUES_RX_DROPCNT_EN
    logic [15:0] DROPCNT;
    logic        DROPCLR;
`endif

    cues_tok_rx_mem1 #(
        .DW(8),
        .DEPTH(4),
        .SYNC_STAGES(2)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .SENDIN (SENDIN),
        .EXBIN  (EXBIN),
        .DATAIN (DATAIN),
        .ACKOUT (ACKOUT),
        .DOUT   (DOUT),
        .DVALID (DVALID),
        .DREADY (DREADY),
        .LEVEL  (LEVEL)
`ifdef CUES_RX_DROPCNT_EN
        ,
        .DROPCNT(DROPCNT),
        .DROPCLR(DROPCLR)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] exp_q[$];
    logic       track_lvl = 1'b0;
    int         max_lvl   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: every pop is compared against the oldest pushed keep token.
    always @(negedge CLK) begin
        if (DVALID && DREADY && !RESET) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", {24'd0, DOUT}, 32'hFFFF_FFFF);
            end else begin
                chk("pop_data", {24'd0, DOUT}, {24'd0, exp_q.pop_front()});
            end
        end
        if (track_lvl && (int'(LEVEL) > max_lvl)) begin
            max_lvl = int'(LEVEL);
        end
    end

    // Full 4-phase handshake; returns the edge counts to ACKOUT rise and fall.
    task automatic send(input logic [7:0] d, input logic e, output int rise, output int fall);
        DATAIN = d;
        EXBIN  = e;
        SENDIN = 1'b1;
        if (e) exp_q.push_back(d);
        rise = 0;
        while (!ACKOUT && rise < 50) begin
            tick();
            rise++;
        end
        SENDIN = 1'b0;
        fall = 0;
        while (ACKOUT && fall < 50) begin
            tick();
            fall++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        DREADY = 1'b1;
        while (LEVEL != 3'd0 && n < 20) begin
            tick();
            n++;
        end
        DREADY = 1'b0;
        chk("drain_level", {29'd0, LEVEL}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       exb;
        logic [2:0] lvl;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int rise;
        int fall;
        int n;

        tbl[0] = '{8'h11, 1'b0, 3'd0};
        tbl[1] = '{8'h22, 1'b0, 3'd0};
        tbl[2] = '{8'h33, 1'b0, 3'd0};
        tbl[3] = '{8'h01, 1'b1, 3'd1};
        tbl[4] = '{8'h02, 1'b1, 3'd2};
        tbl[5] = '{8'h03, 1'b1, 3'd3};
        tbl[6] = '{8'h04, 1'b1, 3'd4};

        RESET  = 1'b1;
        SENDIN = 1'b0;
        EXBIN  = 1'b0;
        DATAIN = 8'h00;
        DREADY = 1'b0;
`ifdef CUES_RX_DROPCNT_EN
        DROPCLR = 1'b0;
`endif
        tick();
        tick();
        tick();
        RESET = 1'b0;

        // Reset state
        chk("rst_ackout", {31'd0, ACKOUT}, 32'd0);
        chk("rst_dvalid", {31'd0, DVALID}, 32'd0);
        chk("rst_level",  {29'd0, LEVEL},  32'd0);
        chk("rst_dout",   {24'd0, DOUT},   32'd0);
`ifdef CUES_RX_DROPCNT_EN
        chk("rst_dropcnt", {16'd0, DROPCNT}, 32'd0);
`endif

        // Single keep token
        send(8'hA5, 1'b1, rise, fall);
        chk("single_rise", rise, 32'd3);
        chk("single_fall", fall, 32'd3);
        chk("single_dvalid", {31'd0, DVALID}, 32'd1);
        chk("single_dout", {24'd0, DOUT}, 32'h0000_00A5);
        chk("single_level", {29'd0, LEVEL}, 32'd1);
        drain();
        chk("empty_dout", {24'd0, DOUT}, 32'd0);

        // Table: three discards, then fill the FIFO with DREADY low
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].data, tbl[i].exb, rise, fall);
            chk("tbl_rise", rise, 32'd3);
            chk("tbl_fall", fall, 32'd3);
            chk("tbl_level", {29'd0, LEVEL}, {29'd0, tbl[i].lvl});
            chk("tbl_dvalid", {31'd0, DVALID}, {31'd0, (tbl[i].lvl != 3'd0)});
`ifdef CUES_RX_DROPCNT_EN
            if (i == 2) chk("dropcnt_3", {16'd0, DROPCNT}, 32'd3);
`endif
        end

        // Fifth keep token stalls while full
        DATAIN = 8'h05;
        EXBIN  = 1'b1;
        SENDIN = 1'b1;
        exp_q.push_back(8'h05);
        for (int i = 0; i < 6; i++) tick();
        chk("full_ack_held", {31'd0, ACKOUT}, 32'd0);
        chk("full_level", {29'd0, LEVEL}, 32'd4);
        DREADY = 1'b1;
        tick();
        DREADY = 1'b0;
        // Pop edge: slot freed but the write waits for the registered level.
        chk("pop_edge_ack", {31'd0, ACKOUT}, 32'd0);
        chk("pop_edge_level", {29'd0, LEVEL}, 32'd3);
        tick();
        chk("after_pop_ack", {31'd0, ACKOUT}, 32'd1);
        chk("after_pop_level", {29'd0, LEVEL}, 32'd4);
        SENDIN = 1'b0;
        n = 0;
        while (ACKOUT && n < 50) begin
            tick();
            n++;
        end
        chk("stall_fall", n, 32'd3);
        chk("stall_head", {24'd0, DOUT}, 32'h0000_0002);
        drain();
        chk("queue_empty_1", exp_q.size(), 32'd0);

        // Streaming with DREADY high: order preserved, level never above 1
        DREADY    = 1'b1;
        max_lvl   = 0;
        track_lvl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(8'(i), 1'b1, rise, fall);
            chk("stream_rise", rise, 32'd3);
        end
        tick();
        tick();
        track_lvl = 1'b0;
        DREADY    = 1'b0;
        chk("stream_max_level", max_lvl, 32'd1);
        chk("stream_level", {29'd0, LEVEL}, 32'd0);
        chk("queue_empty_2", exp_q.size(), 32'd0);

        // Reset in the middle of a handshake
        send(8'hAA, 1'b1, rise, fall);
        DATAIN = 8'hBB;
        EXBIN  = 1'b1;
        SENDIN = 1'b1;
        n = 0;
        while (!ACKOUT && n < 50) begin
            tick();
            n++;
        end
        chk("mid_level", {29'd0, LEVEL}, 32'd2);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        exp_q.delete();
        chk("mid_rst_ackout", {31'd0, ACKOUT}, 32'd0);
        chk("mid_rst_dvalid", {31'd0, DVALID}, 32'd0);
        chk("mid_rst_level",  {29'd0, LEVEL},  32'd0);
        chk("mid_rst_dout",   {24'd0, DOUT},   32'd0);
        exp_q.push_back(8'hBB);
        n = 0;
        while (!ACKOUT && n < 50) begin
            tick();
            n++;
        end
        chk("post_rst_rise", n, 32'd3);
        SENDIN = 1'b0;
        n = 0;
        while (ACKOUT && n < 50) begin
            tick();
            n++;
        end
        chk("post_rst_level", {29'd0, LEVEL}, 32'd1);
        chk("post_rst_dout", {24'd0, DOUT}, 32'h0000_00BB);
        drain();
        chk("queue_empty_3", exp_q.size(), 32'd0);

`ifdef CUES_RX_DROPCNT_EN
        // Saturation and clear-wins-over-drop
        force dut.drop_cnt_q = 16'hFFFE;
        tick();
        release dut.drop_cnt_q;
        send(8'h00, 1'b0, rise, fall);
        chk("sat_ffff_1", {16'd0, DROPCNT}, 32'h0000_FFFF);
        send(8'h00, 1'b0, rise, fall);
        chk("sat_ffff_2", {16'd0, DROPCNT}, 32'h0000_FFFF);
        EXBIN  = 1'b0;
        SENDIN = 1'b1;
        tick();
        tick();
        DROPCLR = 1'b1;
        tick();
        DROPCLR = 1'b0;
        chk("clr_drop_ack", {31'd0, ACKOUT}, 32'd1);
        chk("clr_drop_cnt", {16'd0, DROPCNT}, 32'd0);
        SENDIN = 1'b0;
        for (int i = 0; i < 5; i++) tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
